test_runner_monitor: RTL and testbench
======================================

# test_runner_monitor

Sequential harness controller that consumes the `fail`/`finish` status pair produced by the CI test modules. Holds each test in reset, releases tests one at a time, and waits for `finish` or an optional watchdog timeout. Latches per-test results and reports an aggregate pass/fail. Sits at the top of the CI simulation, above the test instances, and replaces per-bench ad-hoc termination logic.

## Interface
- `NUM_TESTS`, 4: number of attached test slots, 1..32.
- `RESET_CYCLES`, 2: cycles a test's reset is held after selection, ≥1.
- `TIMEOUT`, 1024: RUN cycles allowed before the watchdog fires, ≥1. Used only with `RUNNER_TIMEOUT_EN`.
- `IDX_W`, `max(1,$clog2(NUM_TESTS))`: index width (localparam).

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `start` in 1: one-cycle pulse that begins a campaign; ignored unless the FSM is in IDLE or DONE.
- `test_fail` in NUM_TESTS: per-slot `fail` from the test modules.
- `test_finish` in NUM_TESTS: per-slot `finish` from the test modules.
- `test_reset` out NUM_TESTS: per-slot active-high reset to the test modules; 1 holds the test in reset.
- `busy` out 1: campaign in progress.
- `done` out 1: campaign complete; held until the next `start` or `reset`.
- `pass` out 1: valid while `done`; 1 iff no failures and no timeouts.
- `cur_test` out IDX_W: slot currently selected.
- `fail_mask` out NUM_TESTS: sticky per-slot failure flags.
- `timeout_mask` out NUM_TESTS: sticky per-slot watchdog flags.
- `total_cycles` out 32: cycles spent with `busy`=1; saturates at all-ones.

## Operation
- States and transitions:
  - IDLE goes to HOLD on `start`.
  - HOLD goes to RUN after RESET_CYCLES cycles.
  - RUN goes to RECORD on `test_finish[cur]` or on watchdog expiry.
  - RECORD goes to HOLD with `cur_test`+1, or to DONE when `cur_test`==NUM_TESTS-1.
  - DONE goes to HOLD on `start`.
- Reset values: state IDLE, `test_reset` all ones, `busy`=0, `done`=0, `pass`=0, `cur_test`=0, masks 0, `total_cycles`=0.
- Accepted `start`: clears `cur_test`, both masks, `total_cycles`, `done` and `pass`.
- `test_reset[k]` is 0 only while state is RUN and `cur_test`==k. It is 1 in every other state and for every other slot.
- In RUN, `fail_mask[cur]` is set on any cycle where `test_fail[cur]`=1, including the finish cycle. This latch is sticky.
- Inputs from unselected slots are ignored.
- Watchdog: `run_cnt` clears on RUN entry and increments every RUN cycle. If it reaches TIMEOUT-1 without `finish`, `timeout_mask[cur]` is set and the FSM moves to RECORD.
- Simultaneous `finish` and timeout: `finish` wins and `timeout_mask` stays 0.
- `pass` is computed in RECORD of the last slot as `~|fail_mask & ~|timeout_mask`. This evaluation includes the same-cycle update.

## Timing
- `start` high at edge t: HOLD from t+1, with `busy`=1 from t+1.
- `test_reset[0]` falls at t+1+RESET_CYCLES.
- `finish` sampled at edge f: RECORD at f+1, with `test_reset[cur]`=1 from f+1.
- Next slot: HOLD at f+2.
- Last slot: DONE at f+2, with `done`=1 and `busy`=0 from f+2.
- Per-test overhead: RESET_CYCLES+1 cycles plus the run length.
- `reset` asserted mid-campaign: all outputs return to reset values immediately (async). Results are lost; a new `start` is required.
- `start` during HOLD, RUN or RECORD: no effect.

## Configuration
- `RUNNER_TIMEOUT_EN` defined: the watchdog is built as described.
- Not defined:
  - No `run_cnt` is built.
  - RUN waits indefinitely for `finish`.
  - `timeout_mask` is tied to 0.
  - `pass` depends on `fail_mask` only.

## Test plan
- NUM_TESTS=2, RESET_CYCLES=2. Both slots assert `finish` 3 RUN cycles after release with `fail`=0. Required: `done`=1, `pass`=1, `fail_mask`=2'b00, `total_cycles`=14.
- Slot 1 asserts `fail`=1 together with `finish`. Required: `fail_mask`=2'b10, `pass`=0. Slot 0 is unaffected.
- With `RUNNER_TIMEOUT_EN` and TIMEOUT=8, slot 0 never finishes. Required: RECORD after exactly 8 RUN cycles, `timeout_mask`=2'b01, and slot 1 still runs. Final `pass`=0.
- `reset` is driven low while slot 1 is in RUN. Required, same cycle: `test_reset`=2'b11, `busy`=0, masks 0.
- A `start` pulse mid-RUN is ignored. A `start` pulse in DONE clears the masks and reruns from slot 0.
- `finish` and watchdog expiry occur on the same cycle. Required: `timeout_mask` bit is 0, and `fail_mask` follows `fail`.

Source files
------------

// File: rtl/test_runner_monitor.sv
// Sequential CI harness: releases attached tests one at a time, latches fail/timeout
// per slot and reports an aggregate pass. Define RUNNER_TIMEOUT_EN to build the RUN watchdog.
module test_runner_monitor #(
  parameter int NUM_TESTS    = 4,
  parameter int RESET_CYCLES = 2,
  parameter int TIMEOUT      = 1024,
  localparam int IDX_W       = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_TESTS-1:0] test_fail,
  input  logic [NUM_TESTS-1:0] test_finish,
  output logic [NUM_TESTS-1:0] test_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [IDX_W-1:0]     cur_test,
  output logic [NUM_TESTS-1:0] fail_mask,
  output logic [NUM_TESTS-1:0] timeout_mask,
  output logic [31:0]          total_cycles,
  output logic [2:0]           dbg_state
);

  localparam int HC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HOLD   = 3'd1,
    S_RUN    = 3'd2,
    S_RECORD = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Illegal parameter combinations elaborate to this empty marker block.
  if (NUM_TESTS < 1 || NUM_TESTS > 32 || RESET_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_params
  end

  state_t               state_q;
  logic [NUM_TESTS-1:0] test_reset_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic [IDX_W-1:0]     cur_q;
  logic [NUM_TESTS-1:0] fail_mask_q;
  logic [31:0]          total_q;
  logic [HC_W-1:0]      hold_cnt_q;
`ifdef RUNNER_TIMEOUT_EN
  localparam int RC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [RC_W-1:0]      run_cnt_q;
  logic [NUM_TESTS-1:0] timeout_mask_q;
`endif

  // start is a single-cycle request, honoured only from IDLE or DONE; a slot's
  // finish is only looked at while that slot is the one released in RUN.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      test_reset_q   <= '1;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
      cur_q          <= '0;
      fail_mask_q    <= '0;
      total_q        <= '0;
      hold_cnt_q     <= '0;
`ifdef RUNNER_TIMEOUT_EN
      run_cnt_q      <= '0;
      timeout_mask_q <= '0;
`endif
    end else begin
      if (busy_q && (total_q != 32'hFFFF_FFFF)) total_q <= total_q + 32'd1;

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q        <= S_HOLD;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            cur_q          <= '0;
            fail_mask_q    <= '0;
            total_q        <= '0;
            hold_cnt_q     <= '0;
`ifdef RUNNER_TIMEOUT_EN
            timeout_mask_q <= '0;
`endif
          end
        end

        S_HOLD: begin
          if (hold_cnt_q == HC_W'(RESET_CYCLES - 1)) begin
            state_q      <= S_RUN;
            test_reset_q <= ~(NUM_TESTS'(1) << cur_q);
`ifdef RUNNER_TIMEOUT_EN
            run_cnt_q    <= '0;
`endif
          end else begin
            hold_cnt_q <= hold_cnt_q + HC_W'(1);
          end
        end

        S_RUN: begin
          if (test_fail[cur_q]) fail_mask_q[cur_q] <= 1'b1;
          // finish takes priority over a watchdog expiry on the same cycle
          if (test_finish[cur_q]) begin
            state_q      <= S_RECORD;
            test_reset_q <= '1;
          end
`ifdef RUNNER_TIMEOUT_EN
          else if (run_cnt_q == RC_W'(TIMEOUT - 1)) begin
            state_q               <= S_RECORD;
            test_reset_q          <= '1;
            timeout_mask_q[cur_q] <= 1'b1;
          end else begin
            run_cnt_q <= run_cnt_q + RC_W'(1);
          end
`endif
        end

        S_RECORD: begin
          if (cur_q == IDX_W'(NUM_TESTS - 1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`ifdef RUNNER_TIMEOUT_EN
            pass_q  <= ~|fail_mask_q & ~|timeout_mask_q;
`else
            pass_q  <= ~|fail_mask_q;
`endif
          end else begin
            state_q    <= S_HOLD;
            cur_q      <= cur_q + IDX_W'(1);
            hold_cnt_q <= '0;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign test_reset   = test_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign cur_test     = cur_q;
  assign fail_mask    = fail_mask_q;
  assign total_cycles = total_q;
  assign dbg_state    = state_q;
`ifdef RUNNER_TIMEOUT_EN
  assign timeout_mask = timeout_mask_q;
`else
  assign timeout_mask = '0;
`endif

endmodule

// File: tb/tb_test_runner_monitor.sv
// Bench for test_runner_monitor: behavioural test slots respond to test_reset, and
// per-campaign results are queued at start and checked when done rises.
module tb_test_runner_monitor;

  localparam int NT = 2;
  localparam int RC = 2;
  localparam int TO = 8;
  localparam int W  = 1 + 2 * NT + 32;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_HOLD = 3'd1, ST_RECORD = 3'd3, ST_DONE = 3'd4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [NT-1:0] test_fail = '0;
  logic [NT-1:0] test_finish = '0;
  logic [NT-1:0] test_reset;
  logic          busy, done, pass;
  logic [0:0]    cur_test;
  logic [NT-1:0] fail_mask, timeout_mask;
  logic [31:0]   total_cycles;
  logic [2:0]    dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  test_runner_monitor #(.NUM_TESTS(NT), .RESET_CYCLES(RC), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start),
    .test_fail(test_fail), .test_finish(test_finish), .test_reset(test_reset),
    .busy(busy), .done(done), .pass(pass), .cur_test(cur_test),
    .fail_mask(fail_mask), .timeout_mask(timeout_mask),
    .total_cycles(total_cycles), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset_state();
    reset = 1'b0;
    tick(); tick();
    n_cmp++; if (test_reset !== 2'b11) begin n_err++; $display("FAIL rst_test_reset got=%b exp=11", test_reset); end
    n_cmp++; if ({busy, done, pass} !== 3'b000) begin n_err++; $display("FAIL rst_flags got=%b exp=000", {busy, done, pass}); end
    n_cmp++; if ({fail_mask, timeout_mask} !== 4'b0000) begin n_err++; $display("FAIL rst_masks got=%b exp=0000", {fail_mask, timeout_mask}); end
    n_cmp++; if (total_cycles !== 32'd0 || cur_test !== 1'b0) begin n_err++; $display("FAIL rst_counters total=%0d cur=%0d exp=0,0", total_cycles, cur_test); end
    reset = 1'b1;
    tick(); tick();
    n_cmp++; if (dbg_state !== ST_IDLE || busy !== 1'b0) begin n_err++; $display("FAIL rst_idle state=%0d busy=%b exp=0,0", dbg_state, busy); end
  endtask

  // fm[0]: fail together with finish; fm[1]: fail pulse on the first released cycle.
  // fin >= TO means the slot never finishes (only used with the watchdog built).
  task automatic run_campaign(input string name, input int fin0, input int fin1,
                              input logic [1:0] fm0, input logic [1:0] fm1,
                              input bit start_mid, input bit abort);
    int fin[NT];
    logic [1:0] fm[NT];
    int rel[NT];
    int run_len[NT];
    int etot;
    logic [NT-1:0] efail, eto, first_rel;
    logic epass;
    logic [W-1:0] exp_v;
    bit finished;
    fin[0] = fin0; fin[1] = fin1; fm[0] = fm0; fm[1] = fm1;
    efail = '0; eto = '0; etot = 0;
    first_rel = ~NT'(1);
    for (int s = 0; s < NT; s++) begin
      rel[s] = 0;
      run_len[s] = fin[s] + 1;
`ifdef RUNNER_TIMEOUT_EN
      if (fin[s] >= TO) begin run_len[s] = TO; eto[s] = 1'b1; end
`endif
      if (fm[s][1] || (fm[s][0] && !eto[s])) efail[s] = 1'b1;
      etot += RC + run_len[s] + 1;
    end
    epass = ~|efail & ~|eto;
    if (!abort) exp_q.push_back({epass, eto, efail, 32'(etot)});

    test_finish = NT'($urandom_range(0, 3));
    test_fail   = NT'($urandom_range(0, 3));
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1 || dbg_state !== ST_HOLD || test_reset !== 2'b11) begin
      n_err++; $display("FAIL %s start_accept busy=%b state=%0d trst=%b exp=1,1,11", name, busy, dbg_state, test_reset); end
    n_cmp++; if ({done, pass, fail_mask, timeout_mask} !== 6'b0 || total_cycles !== 32'd0 || cur_test !== 1'b0) begin
      n_err++; $display("FAIL %s start_clear done=%b pass=%b fm=%b tm=%b total=%0d cur=%0d exp all 0", name, done, pass, fail_mask, timeout_mask, total_cycles, cur_test); end

    finished = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      if (cyc == RC) begin
        n_cmp++; if (test_reset !== first_rel) begin n_err++; $display("FAIL %s release0 trst=%b exp=%b", name, test_reset, first_rel); end
      end
      if (dbg_state == ST_RECORD) begin
        n_cmp++; if (rel[cur_test] !== run_len[cur_test] || test_reset !== 2'b11) begin
          n_err++; $display("FAIL %s run_len slot=%0d got=%0d exp=%0d trst=%b", name, cur_test, rel[cur_test], run_len[cur_test], test_reset); end
      end
      if (done) begin
        finished = 1'b1;
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++; $display("FAIL %s scoreboard_empty got=done exp=queued result", name);
        end else begin
          exp_v = exp_q.pop_front();
          n_cmp++; if (pass !== exp_v[W-1]) begin n_err++; $display("FAIL %s pass got=%b exp=%b", name, pass, exp_v[W-1]); end
          n_cmp++; if (timeout_mask !== exp_v[2*NT+31:NT+32]) begin n_err++; $display("FAIL %s timeout_mask got=%b exp=%b", name, timeout_mask, exp_v[2*NT+31:NT+32]); end
          n_cmp++; if (fail_mask !== exp_v[NT+31:32]) begin n_err++; $display("FAIL %s fail_mask got=%b exp=%b", name, fail_mask, exp_v[NT+31:32]); end
          n_cmp++; if (total_cycles !== exp_v[31:0]) begin n_err++; $display("FAIL %s total_cycles got=%0d exp=%0d", name, total_cycles, exp_v[31:0]); end
          n_cmp++; if (busy !== 1'b0 || dbg_state !== ST_DONE || test_reset !== 2'b11) begin
            n_err++; $display("FAIL %s done_state busy=%b state=%0d trst=%b exp=0,4,11", name, busy, dbg_state, test_reset); end
        end
      end else begin
        for (int s = 0; s < NT; s++) begin
          if (!test_reset[s]) begin
            test_finish[s] = (rel[s] == fin[s]);
            test_fail[s]   = (fm[s][0] && rel[s] == fin[s]) || (fm[s][1] && rel[s] == 0);
            rel[s]++;
          end else begin
            test_finish[s] = 1'($urandom_range(0, 1));
            test_fail[s]   = 1'($urandom_range(0, 1));
          end
        end
        start = start_mid && !test_reset[0] && rel[0] == 2;
        if (abort && !test_reset[1] && rel[1] == 2) begin
          n_cmp++; if (fail_mask[0] !== efail[0]) begin n_err++; $display("FAIL %s pre_abort_fail got=%b exp=%b", name, fail_mask[0], efail[0]); end
          reset = 1'b0;
          #1;
          n_cmp++; if (test_reset !== 2'b11 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL %s abort_outputs trst=%b busy=%b done=%b exp=11,0,0", name, test_reset, busy, done); end
          n_cmp++; if ({fail_mask, timeout_mask} !== 4'b0 || total_cycles !== 32'd0) begin
            n_err++; $display("FAIL %s abort_clear fm=%b tm=%b total=%0d exp=0", name, fail_mask, timeout_mask, total_cycles); end
          tick();
          reset = 1'b1;
          tick(); tick(); tick();
          n_cmp++; if (dbg_state !== ST_IDLE || busy !== 1'b0) begin
            n_err++; $display("FAIL %s abort_stays_idle state=%0d busy=%b exp=0,0", name, dbg_state, busy); end
          finished = 1'b1;
        end else begin
          tick();
          start = 1'b0;
        end
      end
    end
    if (!finished) begin
      n_cmp++; n_err++; $display("FAIL %s budget got=no done exp=done within 400 cycles", name);
    end
    test_finish = '0;
    test_fail   = '0;
    tick();
  endtask

  task automatic test_all_pass();
    run_campaign("all_pass", 3, 3, 2'b00, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_fail_latch();
    run_campaign("fail_slot1", 3, 3, 2'b00, 2'b01, 1'b0, 1'b0);
    run_campaign("fail_early", 4, 1, 2'b10, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_campaign("start_mid_run", 5, 2, 2'b01, 2'b00, 1'b1, 1'b0);
    run_campaign("rerun_clears", 2, 4, 2'b00, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++)
      run_campaign("random", int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
`ifdef RUNNER_TIMEOUT_EN
    run_campaign("timeout_slot0", 1000, 2, 2'b00, 2'b00, 1'b0, 1'b0);
    run_campaign("finish_at_expiry_fail", TO - 1, 0, 2'b01, 2'b00, 1'b0, 1'b0);
    run_campaign("finish_at_expiry_pass", TO - 1, TO - 1, 2'b00, 2'b00, 1'b0, 1'b0);
`else
    run_campaign("long_run", 20, 12, 2'b00, 2'b00, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_reset_mid_run();
    run_campaign("abort_slot1", 3, 50, 2'b01, 2'b00, 1'b0, 1'b1);
    run_campaign("after_abort", 1, 1, 2'b00, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset_state();
    test_all_pass();
    test_fail_latch();
    test_start_ignored();
    test_back_to_back();
    test_timeout();
    test_reset_mid_run();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL leftover_results got=%0d exp=0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
